instr_exec_sequencer: RTL and testbench

Sequencer that walks a range of entries in the 32-entry instruction register and executes each stored instruction. For each entry it reads `instruction_t`, computes the result with a shared multi-cycle ALU, and writes the 64-bit result back to the same entry. It sits beside the instruction register: it owns the read pointer and the result write-back port, and it is started by the testbench or top-level control.

---
 rtl/instr_register_pkg.sv | 50 +++++
 rtl/instr_exec_sequencer_alu.sv | 141 ++++++++++++++
 rtl/instr_exec_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_exec_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution sequencer.
package instr_register_pkg;

  localparam int DEF_CNT_W   = 6;
  localparam int ITER_CYCLES = 32;

  typedef logic [4:0]          address_t;
  typedef logic signed [31:0]  operand_t;
  typedef logic signed [63:0]  operand_result;
  typedef logic [DEF_CNT_W-1:0] count_t;

  // Encodings 9..15 are unassigned and treated as illegal.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    FIN   = 3'd4
  } exec_state_t;

  function automatic logic is_long_op(input opcode_t opc);
    return (opc == DIV) || (opc == MOD) || (opc == POW);
  endfunction

  // Magnitude of a signed operand; -2**31 maps to 2**31 as unsigned.
  function automatic logic [31:0] mag32(input operand_t v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

endpackage

// File: rtl/instr_exec_sequencer_alu.sv
// Shared multi-cycle ALU: single-cycle short ops, 32-step restoring divider
// and 32-step square-and-multiply power, with sign fix-up on the output.
module instr_alu
  import instr_register_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  opcode_t       i_opcode,
  input  operand_t      i_op_a,
  input  operand_t      i_op_b,
  output operand_result o_result,
  output logic          o_valid,
  output logic          o_illegal
);

  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_short;
  logic        w_illegal;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;

  opcode_t     r_opc;
  logic [63:0] r_res;
  logic        r_illegal;
  logic        r_short_vld;
  logic        r_run;
  logic [4:0]  r_cnt;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_b_zero;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [63:0] r_acc;
  logic [63:0] r_base;
  logic [31:0] r_exp;

  assign w_a64     = {{32{i_op_a[31]}}, i_op_a};
  assign w_b64     = {{32{i_op_b[31]}}, i_op_b};
  assign w_illegal = (i_opcode > POW);
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};

  // single-cycle results, captured when the operation starts
  always_comb begin
    w_short = '0;
    case (i_opcode)
      PASSA:   w_short = w_a64;
      PASSB:   w_short = w_b64;
      ADD:     w_short = w_a64 + w_b64;
      SUB:     w_short = w_a64 - w_b64;
      MULT:    w_short = w_a64 * w_b64;
      default: w_short = '0;
    endcase
  end

  // operand capture and iterative divide / power steps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opc       <= ZERO;
      r_res       <= '0;
      r_illegal   <= 1'b0;
      r_short_vld <= 1'b0;
      r_run       <= 1'b0;
      r_cnt       <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
    end else if (i_abort) begin
      r_short_vld <= 1'b0;
      r_run       <= 1'b0;
    end else if (i_start) begin
      r_opc       <= i_opcode;
      r_res       <= w_short;
      r_illegal   <= w_illegal;
      r_short_vld <= !is_long_op(i_opcode);
      r_run       <= is_long_op(i_opcode);
      r_cnt       <= 5'(ITER_CYCLES - 1);
      r_neg_a     <= i_op_a[31];
      r_neg_b     <= i_op_b[31];
      r_b_zero    <= (i_op_b == 32'sd0);
      r_rem       <= '0;
      r_quo       <= mag32(i_op_a);
      r_dvs       <= mag32(i_op_b);
      r_acc       <= 64'd1;
      r_base      <= w_a64;
      r_exp       <= i_op_b;
    end else begin
      r_short_vld <= 1'b0;
      if (r_run) begin
        if (r_opc == POW) begin
          if (r_exp[0]) r_acc <= r_acc * r_base;
          r_base <= r_base * r_base;
          r_exp  <= {1'b0, r_exp[31:1]};
        end else begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd0) r_run <= 1'b0;
      end
    end
  end

  // sign fix-up and special cases applied to the iterative results
  always_comb begin
    o_result = r_res;
    case (r_opc)
      DIV: begin
        if (r_b_zero)               o_result = '0;
        else if (r_neg_a ^ r_neg_b) o_result = 64'd0 - {32'd0, r_quo};
        else                        o_result = {32'd0, r_quo};
      end
      MOD: begin
        if (r_b_zero)     o_result = '0;
        else if (r_neg_a) o_result = 64'd0 - {32'd0, r_rem};
        else              o_result = {32'd0, r_rem};
      end
      POW:     o_result = r_neg_b ? '0 : r_acc;
      default: o_result = r_res;
    endcase
  end

  assign o_valid   = r_short_vld | (r_run && (r_cnt == 5'd0));
  assign o_illegal = r_illegal;

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a range of instruction-register entries, executes each one on the
// shared ALU and writes the 64-bit result back to the same entry.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read_pointer drives the entry, ALU captures the instruction
// EXEC  | ALU working (1 cycle short ops, 32 cycles DIV/MOD/POW)
// WB    | write strobe for the result, advance address and count
// FIN   | one-cycle done pulse
module instr_exec_sequencer
  import instr_register_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  address_t         start_addr,
  input  logic [CNT_W-1:0] instr_count,
  input  logic             abort,
  output address_t         read_pointer,
  input  instruction_t     instruction_word,
  output logic             wb_en,
  output address_t         wb_pointer,
  output operand_result    wb_result,
  output logic             illegal_opc,
  output logic             busy,
  output logic             done
);

  exec_state_t      r_state;
  exec_state_t      w_next_state;
  address_t         r_addr;
  address_t         r_rd_ptr;
  logic [CNT_W-1:0] r_remaining;
  logic             w_alu_start;
  logic             w_alu_valid;
  logic             w_alu_illegal;
  operand_result    w_alu_result;

  instr_alu u_alu (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (w_alu_start),
    .i_abort   (abort),
    .i_opcode  (instruction_word.opc),
    .i_op_a    (instruction_word.op_a),
    .i_op_b    (instruction_word.op_b),
    .o_result  (w_alu_result),
    .o_valid   (w_alu_valid),
    .o_illegal (w_alu_illegal)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // next-state decode; abort overrides every active state
  always_comb begin
    w_next_state = r_state;
    if (abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next_state = (instr_count == '0) ? FIN : FETCH;
        FETCH:   w_next_state = EXEC;
        EXEC:    if (w_alu_valid) w_next_state = WB;
        WB:      w_next_state = (r_remaining == CNT_W'(1)) ? FIN : FETCH;
        FIN:     w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // outputs; write-back fields stay at zero unless the strobe is high
  always_comb begin
    wb_en       = 1'b0;
    wb_pointer  = '0;
    wb_result   = '0;
    illegal_opc = 1'b0;
    done        = 1'b0;
    w_alu_start = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      FETCH: w_alu_start = !abort;
      WB: begin
        if (!abort) begin
          wb_en       = 1'b1;
          wb_pointer  = r_addr;
          wb_result   = w_alu_result;
          illegal_opc = w_alu_illegal;
        end
      end
      FIN:     done = !abort;
      default: ;
    endcase
  end

  assign read_pointer = (r_state == FETCH) ? r_addr : r_rd_ptr;

  // run address, remaining count and held read pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= instr_count;
          end
        end
        FETCH: r_rd_ptr <= r_addr;
        WB: begin
          if (!abort) begin
            r_addr      <= r_addr + 5'd1;
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Directed bench for instr_exec_sequencer with a behavioural instruction memory.
module tb_instr_exec_sequencer;
  import instr_register_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  address_t      start_addr = '0;
  logic [5:0]    instr_count = '0;
  logic          abort = 1'b0;
  address_t      read_pointer;
  instruction_t  instruction_word;
  logic          wb_en;
  address_t      wb_pointer;
  operand_result wb_result;
  logic          illegal_opc;
  logic          busy;
  logic          done;

  instruction_t mem [32];

  typedef struct {
    int          cyc;
    logic [4:0]  ptr;
    logic [63:0] res;
    logic        ill;
  } wb_rec_t;

  wb_rec_t wb_q[$];
  int      done_q[$];
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;

  instr_exec_sequencer #(.CNT_W(6)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .instr_count      (instr_count),
    .abort            (abort),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .wb_en            (wb_en),
    .wb_pointer       (wb_pointer),
    .wb_result        (wb_result),
    .illegal_opc      (illegal_opc),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  always @(negedge clk) begin
    if (wb_en) wb_q.push_back('{cyc, wb_pointer, wb_result, illegal_opc});
    if (done) done_q.push_back(cyc);
  end

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t t;
    t.opc  = o;
    t.op_a = a;
    t.op_b = b;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input address_t a, input logic [5:0] n);
    wb_q.delete();
    done_q.delete();
    start_addr  = a;
    instr_count = n;
    start       = 1'b1;
    cyc         = 0;
    step();
    start       = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_wb(input string tag, input int idx, input int ecyc,
                        input logic [4:0] eptr, input logic [63:0] eres, input logic eill);
    wb_rec_t r;
    r.cyc = -1; r.ptr = '0; r.res = '0; r.ill = 1'b0;
    if (idx < wb_q.size()) r = wb_q[idx];
    chk({tag, "_cyc"}, 64'(r.cyc), 64'(ecyc));
    chk({tag, "_ptr"}, 64'(r.ptr), 64'(eptr));
    chk({tag, "_res"}, r.res, eres);
    chk({tag, "_ill"}, 64'(r.ill), 64'(eill));
  endtask

  task automatic chk_done(input string tag, input int ecyc);
    int d = -1;
    chk({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) d = done_q[0];
    chk({tag, "_done_cyc"}, 64'(d), 64'(ecyc));
  endtask

  task automatic run_single(input string tag, input instruction_t ins,
                            input int ecyc, input logic [63:0] eres, input logic eill);
    mem[10] = ins;
    launch(5'd10, 6'd1);
    run_to_idle(tag, 100);
    chk({tag, "_nwb"}, 64'(wb_q.size()), 64'd1);
    chk_wb(tag, 0, ecyc, 5'd10, eres, eill);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);

    // reset with toggling inputs
    #2 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start       = 1'($urandom_range(0, 1));
      abort       = 1'($urandom_range(0, 1));
      start_addr  = 5'($urandom_range(0, 31));
      instr_count = 6'($urandom_range(1, 32));
      #1;
      chk("rst_res", wb_result, 64'd0);
      chk("rst_ctrl", 64'({read_pointer, wb_en, wb_pointer, illegal_opc, busy, done}), 64'd0);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);

    // two short ops
    mem[3] = mk(ADD, 5, -7);
    mem[4] = mk(MULT, -3, 100000);
    launch(5'd3, 6'd2);
    chk("run1_fetch_ptr", 64'(read_pointer), 64'd3);
    run_to_idle("run1", 50);
    chk("run1_nwb", 64'(wb_q.size()), 64'd2);
    chk_wb("run1_wb0", 0, 3, 5'd3, 64'(-2), 1'b0);
    chk_wb("run1_wb1", 1, 6, 5'd4, 64'(-300000), 1'b0);
    chk_done("run1", 7);
    chk("run1_rdptr_hold", 64'(read_pointer), 64'd4);

    // long ops
    run_single("div", mk(DIV, -7, 2), 34, 64'(-3), 1'b0);
    chk_done("div", 35);
    run_single("mod", mk(MOD, -7, 2), 34, 64'(-1), 1'b0);
    run_single("div0", mk(DIV, 9, 0), 34, 64'd0, 1'b0);
    run_single("pow35", mk(POW, 3, 5), 34, 64'd243, 1'b0);
    run_single("pow_neg", mk(POW, 2, -1), 34, 64'd0, 1'b0);
    run_single("pow00", mk(POW, 0, 0), 34, 64'd1, 1'b0);
    run_single("illegal", mk(opcode_t'(4'd12), 5, 6), 3, 64'd0, 1'b1);

    // wrap from 31 to 0
    mem[30] = mk(PASSA, 11, 99);
    mem[31] = mk(PASSB, 99, -4);
    mem[0]  = mk(SUB, 1, 10);
    launch(5'd30, 6'd3);
    run_to_idle("wrap", 60);
    chk("wrap_nwb", 64'(wb_q.size()), 64'd3);
    chk_wb("wrap_wb0", 0, 3, 5'd30, 64'd11, 1'b0);
    chk_wb("wrap_wb1", 1, 6, 5'd31, 64'(-4), 1'b0);
    chk_wb("wrap_wb2", 2, 9, 5'd0, 64'(-9), 1'b0);
    chk_done("wrap", 10);

    // empty run
    launch(5'd5, 6'd0);
    run_to_idle("empty", 10);
    chk("empty_nwb", 64'(wb_q.size()), 64'd0);
    chk_done("empty", 1);

    // abort during EXEC cycle 10 of a POW
    mem[7] = mk(POW, 3, 5);
    launch(5'd7, 6'd1);
    repeat (10) step();
    chk("abort_busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy_after", 64'(busy), 64'd0);
    repeat (40) step();
    chk("abort_nwb", 64'(wb_q.size()), 64'd0);
    chk("abort_ndone", 64'(done_q.size()), 64'd0);

    // abort coincident with the final write-back
    mem[2] = mk(ADD, 1, 2);
    launch(5'd2, 6'd1);
    repeat (2) step();
    chk("abwb_wb_pending", 64'(wb_en), 64'd1);
    abort = 1'b1;
    #1;
    chk("abwb_wb_masked", 64'(wb_en), 64'd0);
    step();
    abort = 1'b0;
    chk("abwb_busy", 64'(busy), 64'd0);
    repeat (5) step();
    chk("abwb_nwb", 64'(wb_q.size()), 64'd0);
    chk("abwb_ndone", 64'(done_q.size()), 64'd0);

    // start while busy is ignored
    mem[10] = mk(DIV, -7, 2);
    mem[20] = mk(PASSA, 77, 0);
    launch(5'd10, 6'd1);
    repeat (3) step();
    start_addr  = 5'd20;
    instr_count = 6'd1;
    start       = 1'b1;
    step();
    start = 1'b0;
    run_to_idle("ovl", 100);
    repeat (5) step();
    chk("ovl_nwb", 64'(wb_q.size()), 64'd1);
    chk_wb("ovl_wb0", 0, 34, 5'd10, 64'(-3), 1'b0);
    chk_done("ovl", 35);

    // reset in the middle of a DIV, then a clean run
    launch(5'd10, 6'd1);
    repeat (8) step();
    reset_n = 1'b0;
    #1;
    chk("mrst_res", wb_result, 64'd0);
    chk("mrst_ctrl", 64'({read_pointer, wb_en, wb_pointer, illegal_opc, busy, done}), 64'd0);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    mem[3] = mk(ADD, 5, -7);
    launch(5'd3, 6'd1);
    run_to_idle("mrst_run", 50);
    chk("mrst_nwb", 64'(wb_q.size()), 64'd1);
    chk_wb("mrst_wb0", 0, 3, 5'd3, 64'(-2), 1'b0);
    chk_done("mrst", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
